// File: rtl/instr_mem_sync.sv
// Clocked instruction memory with a one-entry registered response, a program-load
// write port, fault detection on fetch addresses and a sticky exit flag.
module instr_mem_sync #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 32,
   parameter int                ADDR_W    = 32,
   parameter int                BYTE_ADDR = 1,
   parameter int                HALT_EN   = 1,
   parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic              rsp_fault,
   output logic              exit,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Full-width index compare: high address bits must never alias onto low words.
   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      logic              mis;
      idx = (BYTE_ADDR != 0) ? (a >> 2) : a;
      mis = (BYTE_ADDR != 0) && (a[1:0] != 2'b00);
      return !mis && (idx < ADDR_W'(DEPTH));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      logic [ADDR_W-1:0] idx;
      idx = (BYTE_ADDR != 0) ? (a >> 2) : a;
      return idx[IDX_W-1:0];
   endfunction

   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic              vld_p1;
   logic [DATA_W-1:0] instr_p1;
   logic              fault_p1;
   logic              exit_q;
   logic              accept;
   logic              rd_ok;
   logic              halt_hit;

   assign req_ready = !reset && !load_en && !exit_q && (!vld_p1 || rsp_ready);
   assign accept    = req_valid && req_ready;
   assign rd_ok     = addr_ok(req_addr);
   assign halt_hit  = (HALT_EN != 0) && (instr_p1 == HALT_WORD);

   always_ff @(posedge clk) begin
      if (load_en && addr_ok(load_addr)) begin
         mem[addr_idx(load_addr)] <= load_data;
      end
   end

   // Stage p0 -> p1: request address resolves into the response register.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1   <= 1'b0;
         instr_p1 <= '0;
         fault_p1 <= 1'b0;
         exit_q   <= 1'b0;
      end else begin
         if (vld_p1 && rsp_ready && (fault_p1 || halt_hit)) begin
            exit_q <= 1'b1;
         end
         if (accept) begin
            vld_p1   <= 1'b1;
            fault_p1 <= !rd_ok;
            instr_p1 <= rd_ok ? mem[addr_idx(req_addr)] : '0;
         end else if (rsp_ready) begin
            vld_p1 <= 1'b0;
         end
      end
   end

   assign rsp_valid = vld_p1;
   assign rsp_instr = instr_p1;
   assign rsp_fault = fault_p1;
   assign exit      = exit_q;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed scenarios plus random traffic, checked by a
// reference model feeding a scoreboard queue drained by an independent monitor.
module tb_instr_mem_sync;

   localparam int          DEPTH     = 32;
   localparam int          BYTE_ADDR = 1;
   localparam int          HALT_EN   = 1;
   localparam logic [31:0] HALT_WORD = 32'h0000_0000;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset, req_valid, rsp_ready, load_en;
   logic [31:0] req_addr, load_addr, load_data;
   logic        req_ready, rsp_valid, rsp_fault, exit;
   logic [31:0] rsp_instr;

   logic        nh_reset, nh_req_valid, nh_rsp_ready, nh_load_en;
   logic [31:0] nh_req_addr, nh_load_addr, nh_load_data;
   logic        nh_req_ready, nh_rsp_valid, nh_rsp_fault, nh_exit;
   logic [31:0] nh_rsp_instr;

   int   n_checks = 0;
   int   n_fail   = 0;
   bit   chk_en   = 1'b0;
   exp_t sb[$];

   always #5 clk = ~clk;

   instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(BYTE_ADDR),
                    .HALT_EN(HALT_EN), .HALT_WORD(HALT_WORD)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_instr(rsp_instr), .rsp_fault(rsp_fault), .exit(exit),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

   instr_mem_sync #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .BYTE_ADDR(BYTE_ADDR),
                    .HALT_EN(0), .HALT_WORD(HALT_WORD)) dut_nh (
      .clk(clk), .reset(nh_reset), .req_valid(nh_req_valid), .req_ready(nh_req_ready),
      .req_addr(nh_req_addr), .rsp_valid(nh_rsp_valid), .rsp_ready(nh_rsp_ready),
      .rsp_instr(nh_rsp_instr), .rsp_fault(nh_rsp_fault), .exit(nh_exit),
      .load_en(nh_load_en), .load_addr(nh_load_addr), .load_data(nh_load_data));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_ok(input logic [31:0] a, output int unsigned idx);
      longint unsigned u;
      u   = a;
      idx = 0;
      if (BYTE_ADDR != 0) begin
         if (u % 4 != 0) return 1'b0;
         u = u / 4;
      end
      if (u >= DEPTH) return 1'b0;
      idx = int'(u);
      return 1'b1;
   endfunction

   // Reference model: predicts handshake outcomes and pushes expected responses.
   initial begin
      bit [31:0]   m_mem [DEPTH] = '{default: 0};
      bit          m_vld = 0, m_exit = 0, m_fault = 0;
      bit [31:0]   m_instr = 0;
      bit          exp_rdy, ok;
      int unsigned idx;
      exp_t        e;
      forever begin
         @(negedge clk);
         exp_rdy = !reset && !load_en && !m_exit && (!m_vld || rsp_ready);
         if (chk_en) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
            chk("exit", 32'(exit), 32'(m_exit));
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         end
         if (reset) begin
            m_vld  = 0;
            m_exit = 0;
            sb.delete();
         end else begin
            if (m_vld && rsp_ready && (m_fault || (HALT_EN != 0 && m_instr == HALT_WORD)))
               m_exit = 1;
            if (req_valid && exp_rdy) begin
               ok      = ref_ok(req_addr, idx);
               e.fault = !ok;
               e.instr = ok ? m_mem[idx] : 32'h0;
               sb.push_back(e);
               m_vld   = 1;
               m_instr = e.instr;
               m_fault = e.fault;
            end else if (rsp_ready) begin
               m_vld = 0;
            end
         end
         if (load_en && ref_ok(load_addr, idx)) m_mem[idx] = load_data;
      end
   end

   // Monitor: compares every presented response against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_en && !reset && rsp_valid) begin
            if (sb.size() == 0) begin
               chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
            end else if (rsp_ready) begin
               e = sb.pop_front();
               chk("rsp_instr", rsp_instr, e.instr);
               chk("rsp_fault", 32'(rsp_fault), 32'(e.fault));
            end else begin
               chk("hold_instr", rsp_instr, sb[0].instr);
               chk("hold_fault", 32'(rsp_fault), 32'(sb[0].fault));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en   = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] a, input logic rdy);
      req_valid = 1'b1;
      req_addr  = a;
      rsp_ready = rdy;
      step();
      req_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
         2:       return 32'($urandom_range(DEPTH, DEPTH + 8) * 4);
         default: return 32'($urandom_range(0, DEPTH - 1) * 4);
      endcase
   endfunction

   initial begin
      reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; load_en = 1'b0;
      req_addr = '0; load_addr = '0; load_data = '0;
      nh_reset = 1'b1; nh_req_valid = 1'b0; nh_rsp_ready = 1'b0; nh_load_en = 1'b0;
      nh_req_addr = '0; nh_load_addr = '0; nh_load_data = '0;
      repeat (3) step();
      reset = 1'b0; nh_reset = 1'b0;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_instr", rsp_instr, 32'h0);
      chk("rst_rsp_fault", 32'(rsp_fault), 32'h0);
      chk("rst_exit", 32'(exit), 32'h0);
      chk_en = 1'b1;

      load(32'd8, 32'h0070_0113);
      load(32'd12, 32'h0020_0223);
      fetch(32'd8, 1'b1);
      fetch(32'd12, 1'b1);
      step();

      // Backpressure: first fetch accepted, then three stalled cycles.
      req_valid = 1'b1; req_addr = 32'd8; rsp_ready = 1'b0;
      repeat (4) step();
      chk("bp_instr", rsp_instr, 32'h0070_0113);
      req_addr = 32'd12; rsp_ready = 1'b1;
      step();
      req_valid = 1'b0;
      step();

      // Load and fetch in the same cycle; fetch goes through one cycle later.
      req_valid = 1'b1; req_addr = 32'd16;
      load_en = 1'b1; load_addr = 32'd16; load_data = 32'h1234_5678;
      step();
      load_en = 1'b0;
      step();
      req_valid = 1'b0;
      step();

      // Reset while a response is held.
      fetch(32'd12, 1'b0);
      repeat (2) step();
      pulse_reset();
      fetch(32'd12, 1'b1);
      step();

      // Misaligned fetch, followed by requests that must be refused after exit.
      fetch(32'd6, 1'b1);
      req_valid = 1'b1; req_addr = 32'd8;
      repeat (4) step();
      req_valid = 1'b0;
      chk("fault_exit", 32'(exit), 32'h1);
      load(32'd20, 32'hcafe_0001);
      pulse_reset();

      fetch(32'h80, 1'b1);
      step();
      pulse_reset();

      // Invalid loads must not land anywhere; load during reset must land.
      load(32'h81, 32'hdead_beef);
      load(32'h80, 32'hdead_beef);
      reset = 1'b1;
      load(32'd24, 32'h0badc0de);
      reset = 1'b0;
      fetch(32'd24, 1'b1);
      fetch(32'd20, 1'b1);
      fetch(32'd0, 1'b1);
      step();
      chk("halt_exit", 32'(exit), 32'h1);
      pulse_reset();

      for (int c = 0; c < 800; c++) begin
         reset     = ($urandom_range(0, 39) == 0) || (exit && $urandom_range(0, 3) == 0);
         load_en   = ($urandom_range(0, 7) == 0);
         load_addr = rand_addr();
         load_data = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
         req_valid = ($urandom_range(0, 2) != 0);
         req_addr  = rand_addr();
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      reset = 1'b0; load_en = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
      repeat (3) step();
      chk("sb_empty", 32'(sb.size()), 32'h0);

      // HALT_EN=0: fetching the halt encoding must not raise exit.
      nh_req_valid = 1'b1; nh_req_addr = 32'd0; nh_rsp_ready = 1'b1;
      step();
      nh_req_valid = 1'b0;
      chk("nh_rsp_valid", 32'(nh_rsp_valid), 32'h1);
      chk("nh_rsp_instr", nh_rsp_instr, 32'h0);
      chk("nh_rsp_fault", 32'(nh_rsp_fault), 32'h0);
      step();
      chk("nh_exit", 32'(nh_exit), 32'h0);
      chk("nh_req_ready", 32'(nh_req_ready), 32'h1);
      chk("nh_drained", 32'(nh_rsp_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, clocked instruction memory for the RV32 core; successor to the combinational instruction ROM.
- Registered read with valid/ready handshake on request and response sides.
- Program-load write port, so the testbench or boot logic fills memory instead of hard-coded contents.
- Flags misaligned and out-of-range fetches; raises a sticky exit on a halt word or fault, which stops the fetch stage.

Parameters:
- DATA_W, 32: instruction width in bits.
- DEPTH, 32: number of words; power of two, at least 2.
- ADDR_W, 32: width of the fetch and load address ports.
- BYTE_ADDR, 1: 1 = addresses are byte addresses, index = addr >> 2; 0 = addresses are word indices.
- HALT_EN, 1: 1 = fetching HALT_WORD raises exit.
- HALT_WORD, 32'h0000_0000: encoding that terminates the program.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  fetch request present.
- req_ready  out  1  block accepts the request this cycle.
- req_addr  in  ADDR_W  fetch address.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response this cycle.
- rsp_instr  out  DATA_W  fetched instruction.
- rsp_fault  out  1  response came from a misaligned or out-of-range address.
- exit  out  1  sticky program-end flag.
- load_en  in  1  write load_data into memory.
- load_addr  in  ADDR_W  load address, same addressing rule as req_addr.
- load_data  in  DATA_W  word to write.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high.
  - At reset: rsp_valid=0, rsp_instr=0, rsp_fault=0, exit=0.
  - Memory array is not cleared by reset. It is zero at time zero, so an unloaded word reads 0.
- Index and fault rules:
  - idx = BYTE_ADDR ? addr[ADDR_W-1:2] : addr.
  - Misaligned: BYTE_ADDR=1 and addr[1:0] != 0.
  - Out of range: idx >= DEPTH. Upper address bits are compared, never truncated, so there is no wrap-around.
- req_ready = !reset && !load_en && !exit && (!rsp_valid || rsp_ready).
- Accept: req_valid && req_ready at edge N.
  - At N+1: rsp_valid=1.
  - If the address is valid: rsp_instr = mem[idx], rsp_fault=0.
  - Otherwise: rsp_instr=0, rsp_fault=1.
  - Latency is exactly 1 cycle.
- Backpressure:
  - While rsp_valid && !rsp_ready: rsp_instr and rsp_fault hold stable, and no new request is accepted.
- Response drain:
  - rsp_valid && rsp_ready with no new accept: rsp_valid->0 next edge. rsp_instr and rsp_fault keep their last value.
  - rsp_valid && rsp_ready with a simultaneous accept: rsp_valid stays 1 and the new data is loaded. Full throughput is 1 fetch per cycle.
- Exit:
  - Set at the edge where a response is consumed (rsp_valid && rsp_ready) and either:
    - rsp_fault=1, or
    - HALT_EN=1 and rsp_instr==HALT_WORD.
  - Cleared only by reset.
  - Once set, no further requests are accepted. An outstanding response still drains normally.
- Load port:
  - load_en=1 at an edge writes mem[idx(load_addr)] = load_data.
  - The write is silently ignored if load_addr is misaligned or out of range.
  - Load has priority: req_ready=0 while load_en=1, so read and write never share a cycle.
  - Load is allowed during reset and while exit=1. The memory write still happens.
- Reset mid-operation: any held response is dropped (rsp_valid=0 next edge) and exit is cleared. Memory contents survive.
- State machine: none beyond the one-entry response register (EMPTY/FULL, encoded by rsp_valid) plus the sticky exit bit.

Test Plan:
- Load then fetch: load 0x00700113 to addr 8, then 0x00200223 to addr 12 (BYTE_ADDR=1). Stream fetches to 8 and 12 with rsp_ready=1 -> rsp_valid 1 cycle after each accept; instr 0x00700113 then 0x00200223 in back-to-back cycles; rsp_fault=0.
- Backpressure: accept fetch of addr 8, hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 throughout; rsp_instr stable at 0x00700113. Raise rsp_ready -> next fetch accepted in the same cycle.
- Faults: fetch addr 0x6 -> rsp_fault=1, rsp_instr=0, exit=1 after consume. Then req_ready=0 for any further request until reset.
  - Separately, after reset, fetch addr 0x80 with DEPTH=32 -> rsp_fault=1; no wrap to index 0.
- Halt word: fetch addr 0 (never loaded) -> rsp_instr=0, consumed, exit=1 the next cycle.
  - With HALT_EN=0: same fetch -> exit stays 0.
- Load/fetch conflict: load_en=1 and req_valid=1 in the same cycle -> req_ready=0; write completes; fetch accepted the next cycle and returns the new data.
- Reset mid-operation: response held under rsp_ready=0, assert reset 1 cycle -> rsp_valid=0 and exit=0 next edge. A subsequent fetch returns the previously loaded data.
